// File: rtl/mux_stream_nto1_if.sv
// mux_stream_nto1_if: select, channel handshakes and output stream of the N-to-1 mux.
// sel_err exists only when MUX_SELERR_EN is defined.
interface mux_stream_nto1_if #(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    parameter int SELW  = 2
);
    logic [SELW-1:0]    sel;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        xfer_cnt;
`ifdef MUX_SELERR_EN
    logic               sel_err;

    modport master (output sel, in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid, xfer_cnt, sel_err);
    modport slave  (input  sel, in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid, xfer_cnt, sel_err);
`else
    modport master (output sel, in_data, in_valid, out_ready,
                    input  in_ready, out_data, out_valid, xfer_cnt);
    modport slave  (input  sel, in_data, in_valid, out_ready,
                    output in_ready, out_data, out_valid, xfer_cnt);
`endif
endinterface

// File: rtl/mux_stream_nto1.sv
// mux_stream_nto1: N-to-1 stream mux with one registered output stage and transfer counter.
// MUX_SELERR_EN adds a sticky flag for valid traffic while sel addresses a missing channel.
module mux_stream_nto1 #(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input logic              clk,
    input logic              rst_n,
    mux_stream_nto1_if.slave s
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t st;
    logic space, sel_ok, take;
    assign space  = !s.out_valid || s.out_ready;
    assign sel_ok = 32'(s.sel) < N;
    // in_ready is one-hot at sel, so masking in_valid with it yields the transfer
    assign s.in_ready  = (rst_n && sel_ok && space) ? N'(1) << s.sel : '0;
    assign take        = |(s.in_valid & s.in_ready);
    assign s.out_valid = st == FULL;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= EMPTY;
            s.out_data <= '0;
            s.xfer_cnt <= '0;
        end else begin
            if (take) begin
                st         <= FULL;
                s.out_data <= s.in_data[s.sel*WIDTH +: WIDTH];
            end else if (s.out_ready) begin
                st <= EMPTY;
            end
            if (s.out_valid && s.out_ready) s.xfer_cnt <= s.xfer_cnt + 16'd1;
        end
    end
`ifdef MUX_SELERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) s.sel_err <= 1'b0;
        else if (!sel_ok && |s.in_valid) s.sel_err <= 1'b1;
    end
`endif
endmodule
